// File: rtl/vector_fetch_pkg.sv
// Shared types, default widths and helpers for the vector fetch engine.
// Counters assume widths of 32 bits or fewer.
package vector_fetch_pkg;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_CNT_W          = 16;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LATCH = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_PUSH  = 3'd5,
        ST_DONE  = 3'd6
    } fetch_state_t;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter
    import vector_fetch_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= CNT_W'(sat_inc(32'(r_cnt), CNT_W));
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/vector_fetch_engine.sv
// Pops vector addresses, issues one single-beat memory read per address and
// pushes the returned word into the vector FIFO, with progress/error status.
module vector_fetch_engine
    import vector_fetch_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_program,
    input  logic              end_program,
    input  logic [ADDR_W-1:0] addr_fifo_dout,
    input  logic              addr_fifo_empty,
    output logic              addr_fifo_rd,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_data_val,
    output logic [DATA_W-1:0] vctr_fifo_din,
    output logic              vctr_fifo_wr,
    input  logic              vctr_fifo_full,
    output logic              fetch_active,
    output logic              fetch_done,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    fetch_state_t      r_state;
    fetch_state_t      w_next;
    logic [ADDR_W-1:0] r_addr_q;
    logic [DATA_W-1:0] r_data;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_addr_rd;
    logic              r_mem_rd;
    logic              r_push;
    logic              r_active;
    logic              r_done;
    logic              r_timeout_err;
    logic              w_to_hit;
    logic              w_push_fire;
    logic              w_stall;

    assign w_to_hit    = (r_state == ST_WAIT) && !mem_rd_data_val && (r_to_cnt == TO_LAST);
    // The push strobe must see the current full flag, so it is qualified
    // combinationally by the registered PUSH-state bit.
    assign w_push_fire = r_push && !vctr_fifo_full;
    assign w_stall     = r_push && vctr_fifo_full;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (end_program) begin
                    w_next = ST_DONE;
                end else if (run_program && !addr_fifo_empty) begin
                    w_next = ST_POP;
                end
            end
            ST_POP:   w_next = ST_LATCH;
            ST_LATCH: w_next = ST_ISSUE;
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT: begin
                if (mem_rd_data_val) begin
                    w_next = ST_PUSH;
                end else if (w_to_hit) begin
                    w_next = ST_IDLE;
                end
            end
            ST_PUSH: begin
                if (!vctr_fifo_full) begin
                    w_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!run_program && !end_program) begin
                    w_next = ST_IDLE;
                end
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_addr_rd     <= 1'b0;
            r_mem_rd      <= 1'b0;
            r_push        <= 1'b0;
            r_active      <= 1'b0;
            r_done        <= 1'b0;
            r_addr_q      <= '0;
            r_data        <= '0;
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_addr_rd <= (w_next == ST_POP);
            r_mem_rd  <= (w_next == ST_ISSUE);
            r_push    <= (w_next == ST_PUSH);
            r_active  <= (w_next != ST_IDLE) && (w_next != ST_DONE);
            r_done    <= (w_next == ST_DONE);
            if (r_state == ST_LATCH) begin
                r_addr_q <= addr_fifo_dout;
            end
            if ((r_state == ST_WAIT) && mem_rd_data_val) begin
                r_data <= mem_rd_data;
            end
            if (r_state == ST_ISSUE) begin
                r_to_cnt <= '0;
            end else if ((r_state == ST_WAIT) && !w_to_hit) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_to_hit) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_push_fire),
        .i_clear (1'b0),
        .o_cnt   (fetch_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_stall),
        .i_clear (1'b0),
        .o_cnt   (stall_cnt)
    );

    assign addr_fifo_rd  = r_addr_rd;
    assign mem_rd        = r_mem_rd;
    assign mem_rd_addr   = r_addr_q;
    assign vctr_fifo_din = r_data;
    assign vctr_fifo_wr  = w_push_fire;
    assign fetch_active  = r_active;
    assign fetch_done    = r_done;
    assign timeout_err   = r_timeout_err;

endmodule
